// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and the parity rule.
// The TX side imports the same package so both ends agree on the frame format.
package uart_rx_ctrl_pkg;

  // Receiver sequencing states, exported on the debug port of uart_rx_ctrl.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Frame: start, DATA_BITS data (LSB first), parity, stop.
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned POST_START_BITS = DATA_BITS + 2;

  // Parity-mode selector values for the PARITY_ODD parameter.
  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  // True when the data byte plus its parity bit has the parity the mode asks for.
  function automatic logic rx_parity_ok(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit,
                                        input logic                 odd);
    return (((^data) ^ pbit) == odd);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Small synchronous first-word-fall-through FIFO holding received bytes.
// Pointers carry one extra MSB so full and empty are distinguishable.
// DEPTH must be a power of two, 2 or larger.
module rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             push_ok,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             pop_do;
  logic             push_do;

  // Status, acceptance and next-pointer logic. A push into a full FIFO is
  // accepted when a pop frees the head slot on the same edge.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_do  = pop & ~empty;
    push_ok = ~full | pop_do;
    push_do = push & push_ok;
    wr_d    = push_do ? (wr_q + 1'b1) : wr_q;
    rd_d    = pop_do  ? (rd_q + 1'b1) : rd_q;
    dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care until written, reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push_do) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes the serial line, times the bit
// samples, validates parity and stop, and queues good bytes in rx_fifo.
//
// Host handshake: o_valid means o_dataout holds the FIFO head. The head is
// consumed on a rising edge where o_valid and i_rd_en are both high; i_rd_en
// while o_valid is low has no effect. The next entry appears the cycle after.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_ODD   = PARITY_MODE_ODD
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_datain,
  input  logic      i_rd_en,
  input  logic      i_clr_err,
  output logic [7:0] o_dataout,
  output logic      o_valid,
  output logic      o_full,
  output logic      o_parity_err,
  output logic      o_frame_err,
  output logic      o_overrun,
  output rx_state_e o_dbg_state
);

  localparam int unsigned    CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_e              state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_ok_q, par_ok_d;
  logic                   armed_q, armed_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic                   s;
  logic                   push_req;
  logic                   push_ok;
  logic                   perr_set;
  logic                   ferr_set;
  logic                   ovr_set;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_dout;

  // Two-stage synchronizer input: shift the raw line in behind the first stage.
  always_comb begin
    sync_d = {sync_q[0], i_datain};
    s      = sync_q[1];
  end

  // Synchronizer flops idle high so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Frame sequencing: baud counter, bit index, shift register and frame checks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    armed_d   = armed_q;
    push_req  = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A line that has been seen high re-arms start detection.
        if (s) begin
          armed_d = 1'b1;
        end
        if (!s && armed_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d    = '0;
          par_ok_d = rx_parity_ok(shift_q, s, PARITY_ODD);
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!s) begin
            // Broken stop bit: stay disarmed until the line is seen high again.
            ferr_set = 1'b1;
            armed_d  = 1'b0;
          end else if (!par_ok_q) begin
            perr_set = 1'b1;
          end else begin
            push_req = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky error flags; a new error event beats a same-cycle clear.
  always_comb begin
    ovr_set = push_req & ~push_ok;
    perr_d  = perr_set | (perr_q & ~i_clr_err);
    ferr_d  = ferr_set | (ferr_q & ~i_clr_err);
    ovr_d   = ovr_set  | (ovr_q  & ~i_clr_err);
  end

  // Controller state registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      armed_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      armed_q   <= armed_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .push    (push_req),
    .din     (shift_q),
    .pop     (i_rd_en),
    .push_ok (push_ok),
    .dout    (fifo_dout),
    .full    (o_full),
    .empty   (fifo_empty)
  );

  // Output mapping.
  always_comb begin
    o_dataout    = fifo_dout;
    o_valid      = ~fifo_empty;
    o_parity_err = perr_q;
    o_frame_err  = ferr_q;
    o_overrun    = ovr_q;
    o_dbg_state  = state_q;
  end

endmodule
